dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (port 0) and debug/DMA (port 1) share one
// word-addressed memory; partial stores become read-merge-write.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_wstrb,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr_out,
  output logic [31:0] write_data_out,
  input  logic [31:0] read_data_in,

  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] merge_q;
  logic [31:0] c_rdata_q, d_rdata_q;
  logic        c_rvalid_q, d_rvalid_q;

  logic        win;
  logic        gnt_any;
  logic        mem_rd;
  logic        mem_wr;
  logic        load_done;
  logic        merge_ld;
  logic [31:0] wr_data;
  logic [31:0] merged;

  always_comb begin
    merged = merge_q;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Tie goes to prio; a lone requester wins outright.
  assign win = (c_req && d_req) ? prio_q : d_req;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    gnt_any   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    load_done = 1'b0;
    merge_ld  = 1'b0;
    wr_data   = 32'h0;

    case (state_q)
      IDLE: begin
        if (c_req || d_req) begin
          id_d    = win;
          we_d    = win ? d_we    : c_we;
          addr_d  = win ? d_addr[31:2] : c_addr[31:2];
          wdata_d = win ? d_wdata : c_wdata;
          wstrb_d = win ? d_wstrb : c_wstrb;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          mem_rd    = 1'b1;
          gnt_any   = 1'b1;
          load_done = 1'b1;
          state_d   = IDLE;
        end else if (wstrb_q == 4'h0) begin
          gnt_any = 1'b1;
          state_d = IDLE;
        end else if (wstrb_q == 4'hF) begin
          mem_wr  = 1'b1;
          wr_data = wdata_q;
          gnt_any = 1'b1;
          state_d = IDLE;
        end else begin
          mem_rd   = 1'b1;
          merge_ld = 1'b1;
          state_d  = MERGE_WR;
        end
      end
      MERGE_WR: begin
        mem_wr  = 1'b1;
        wr_data = merged;
        gnt_any = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (gnt_any) prio_d = ~id_q;

    // An access cut by reset must not touch memory or report completion.
    if (rst) begin
      gnt_any   = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      load_done = 1'b0;
      merge_ld  = 1'b0;
      wr_data   = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      merge_q    <= '0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      c_rvalid_q <= load_done & ~id_q;
      d_rvalid_q <= load_done & id_q;
      if (load_done && !id_q) c_rdata_q <= read_data_in;
      if (load_done && id_q)  d_rdata_q <= read_data_in;
      if (merge_ld)           merge_q   <= read_data_in;
    end
  end

  assign c_gnt          = gnt_any & ~id_q;
  assign d_gnt          = gnt_any & id_q;
  assign c_rvalid       = c_rvalid_q;
  assign d_rvalid       = d_rvalid_q;
  assign c_rdata        = c_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign MemRead        = mem_rd;
  assign MemWrite       = mem_wr;
  assign write_data_out = wr_data;
  assign addr_out       = (state_q == IDLE) ? 32'h0 : {addr_q, 2'b00};
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner sequences,
// and randomized two-port episodes checked against a transaction-level model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_wstrb, d_wstrb;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic        MemRead, MemWrite, busy;
  logic [31:0] addr_out, write_data_out, read_data_in;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr_out(addr_out),
    .write_data_out(write_data_out), .read_data_in(read_data_in),
    .busy(busy)
  );

  // Memory behind the arbiter, plus an independent golden copy for the model.
  logic [31:0] mem [0:255];
  logic [31:0] gm  [0:255];
  assign read_data_in = mem[addr_out[9:2]];
  always @(posedge clk) if (MemWrite) mem[addr_out[9:2]] <= write_data_out;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rd_wr_exclusive", {31'b0, MemRead & MemWrite}, 32'h0);
    chk("gnt_exclusive",   {31'b0, c_gnt & d_gnt}, 32'h0);
    chk("wdata_zero_nowr", MemWrite ? 32'h0 : write_data_out, 32'h0);
    chk("rst_no_mem",      rst ? {30'b0, MemRead, MemWrite} : 32'h0, 32'h0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  function automatic int exp_lat(input bit we, input logic [3:0] s);
    return (we && s != 4'h0 && s != 4'hF) ? 3 : 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive(input bit p, input bit req, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s);
    if (!p) begin
      c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_wstrb = s;
    end else begin
      d_req = req; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = s;
    end
  endtask

  task automatic single(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output int lat, output int nrd, output int nwr,
                        output int rv, output logic [31:0] rd);
    lat = 0; nrd = 0; nwr = 0;
    drive(p, 1'b1, we, a, wd, s);
    for (int cyc = 2; cyc <= 12; cyc++) begin
      tick();
      nrd += int'(MemRead);
      nwr += int'(MemWrite);
      if (p ? d_gnt : c_gnt) begin
        lat = cyc;
        break;
      end
    end
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    rv = int'(p ? d_rvalid : c_rvalid);
    rd = p ? d_rdata : c_rdata;
  endtask

  typedef struct {
    bit          p;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] pre;
    int          lat;
    int          nrd;
    int          nwr;
    int          rv;
    logic [31:0] word;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [9];
  bit   last_p;

  task automatic episode();
    bit          rq [2];
    bit          we [2];
    logic [31:0] ad [2], wd [2], erd [2], ard [2];
    logic [3:0]  st [2];
    int          ec [2], gc [2], gn [2], rvn [2];
    bit          first, p;
    int          t;
    for (int k = 0; k < 2; k++) begin
      rq[k]  = ($urandom_range(0, 3) != 0);
      we[k]  = 1'($urandom_range(0, 1));
      ad[k]  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wd[k]  = $urandom;
      st[k]  = 4'($urandom_range(0, 15));
      ec[k]  = 0; gc[k] = 0; gn[k] = 0; rvn[k] = 0; erd[k] = 0; ard[k] = 0;
    end
    if (!rq[0] && !rq[1]) rq[0] = 1'b1;
    first = (rq[0] && rq[1]) ? !last_p : rq[1];
    t = 0;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : !first;
      if (rq[p]) begin
        t += exp_lat(we[p], st[p]);
        ec[p] = t;
        if (!we[p]) erd[p] = gm[ad[p][9:2]];
        else        gm[ad[p][9:2]] = apply_strb(gm[ad[p][9:2]], wd[p], st[p]);
        last_p = p;
      end
    end
    for (int k = 0; k < 2; k++) if (rq[k]) drive(k[0], 1'b1, we[k], ad[k], wd[k], st[k]);
    for (int cyc = 2; cyc <= t + 1; cyc++) begin
      tick();
      if (c_gnt)    begin gn[0]++; gc[0] = cyc; c_req = 1'b0; end
      if (d_gnt)    begin gn[1]++; gc[1] = cyc; d_req = 1'b0; end
      if (c_rvalid) begin rvn[0]++; ard[0] = c_rdata; end
      if (d_rvalid) begin rvn[1]++; ard[1] = d_rdata; end
    end
    c_req = 1'b0;
    d_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk(k ? "rnd_d_gnt_count" : "rnd_c_gnt_count", gn[k], rq[k] ? 1 : 0);
      chk(k ? "rnd_d_rvalid_count" : "rnd_c_rvalid_count", rvn[k], (rq[k] && !we[k]) ? 1 : 0);
      if (rq[k]) begin
        chk(k ? "rnd_d_gnt_cycle" : "rnd_c_gnt_cycle", gc[k], ec[k]);
        if (!we[k]) chk(k ? "rnd_d_rdata" : "rnd_c_rdata", ard[k], erd[k]);
        else        chk(k ? "rnd_d_mem_word" : "rnd_c_mem_word",
                        mem[ad[k][9:2]], gm[ad[k][9:2]]);
      end
    end
  endtask

  initial begin
    int lat, nrd, nwr, rv, cyc, gcyc;
    logic [31:0] rd;
    bit order [$];

    // p we addr wdata strb preload | lat nrd nwr rv word rdata
    vt[0] = '{1'b0, 1'b0, 32'h40, 32'h0,        4'hF, 32'hCAFEBABE, 2, 1, 0, 1, 32'hCAFEBABE, 32'hCAFEBABE};
    vt[1] = '{1'b1, 1'b1, 32'h44, 32'hAABBCCDD, 4'h6, 32'h11223344, 3, 1, 1, 0, 32'h11BBCC44, 32'h0};
    vt[2] = '{1'b0, 1'b1, 32'h20, 32'h12345678, 4'h0, 32'h55555555, 2, 0, 0, 0, 32'h55555555, 32'h0};
    vt[3] = '{1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h00000000, 2, 0, 1, 0, 32'hDEADBEEF, 32'h0};
    vt[4] = '{1'b1, 1'b0, 32'h80, 32'h0,        4'h0, 32'h89ABCDEF, 2, 1, 0, 1, 32'h89ABCDEF, 32'h89ABCDEF};
    vt[5] = '{1'b0, 1'b1, 32'h10, 32'hFFEEDDCC, 4'h8, 32'h12345678, 3, 1, 1, 0, 32'hFF345678, 32'h0};
    vt[6] = '{1'b1, 1'b1, 32'h14, 32'h00000011, 4'h1, 32'hAAAAAAAA, 3, 1, 1, 0, 32'hAAAAAA11, 32'h0};
    vt[7] = '{1'b1, 1'b1, 32'h7C, 32'h01234567, 4'hF, 32'hFFFFFFFF, 2, 0, 1, 0, 32'h01234567, 32'h0};
    vt[8] = '{1'b0, 1'b0, 32'h43, 32'h0,        4'h0, 32'h0BADF00D, 2, 1, 0, 1, 32'h0BADF00D, 32'h0BADF00D};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_reset(3);

    chk("reset_busy",     {31'b0, busy},     32'h0);
    chk("reset_c_gnt",    {31'b0, c_gnt},    32'h0);
    chk("reset_d_gnt",    {31'b0, d_gnt},    32'h0);
    chk("reset_c_rvalid", {31'b0, c_rvalid}, 32'h0);
    chk("reset_d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("reset_c_rdata",  c_rdata,           32'h0);
    chk("reset_d_rdata",  d_rdata,           32'h0);
    chk("reset_memread",  {31'b0, MemRead},  32'h0);
    chk("reset_memwrite", {31'b0, MemWrite}, 32'h0);
    chk("reset_addr_out", addr_out,          32'h0);

    for (int i = 0; i < 9; i++) begin
      mem[vt[i].addr[9:2]] = vt[i].pre;
      single(vt[i].p, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].strb, lat, nrd, nwr, rv, rd);
      chk($sformatf("vec%0d_latency", i),  lat, vt[i].lat);
      chk($sformatf("vec%0d_memread", i),  nrd, vt[i].nrd);
      chk($sformatf("vec%0d_memwrite", i), nwr, vt[i].nwr);
      chk($sformatf("vec%0d_rvalid", i),   rv,  vt[i].rv);
      chk($sformatf("vec%0d_mem_word", i), mem[vt[i].addr[9:2]], vt[i].word);
      if (vt[i].rv != 0) chk($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
    end

    do_reset(1);
    chk("rereset_c_rdata", c_rdata, 32'h0);
    chk("rereset_d_rdata", d_rdata, 32'h0);

    // Misaligned load: word address on the bus.
    mem[8'h10] = 32'h0BADF00D;
    drive(1'b0, 1'b1, 1'b0, 32'h43, 32'h0, 4'h0);
    tick();
    chk("misalign_addr_out", addr_out, 32'h40);
    chk("misalign_memread", {31'b0, MemRead}, 32'h1);
    chk("misalign_c_gnt", {31'b0, c_gnt}, 32'h1);
    c_req = 1'b0;
    tick();
    chk("misalign_rvalid", {31'b0, c_rvalid}, 32'h1);
    chk("misalign_rdata", c_rdata, 32'h0BADF00D);
    chk("idle_addr_out", addr_out, 32'h0);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // Requester drops and scrambles its inputs mid-access.
    mem[8'h12] = 32'h44556677;
    drive(1'b0, 1'b1, 1'b1, 32'h48, 32'hA1B2C3D4, 4'hC);
    tick();
    chk("drop_access_no_gnt", {31'b0, c_gnt}, 32'h0);
    chk("drop_access_busy", {31'b0, busy}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'hFC, 32'h0, 4'hF);
    tick();
    chk("drop_merge_gnt", {31'b0, c_gnt}, 32'h1);
    chk("drop_merge_memwrite", {31'b0, MemWrite}, 32'h1);
    chk("drop_merge_wdata", write_data_out, 32'hA1B26677);
    chk("drop_merge_addr", addr_out, 32'h48);
    tick();
    chk("drop_mem_word", mem[8'h12], 32'hA1B26677);
    chk("drop_c_gnt_once", {31'b0, c_gnt}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset lands in MERGE_WR; held request must redo the whole access.
    mem[8'h0C] = 32'h11111111;
    drive(1'b1, 1'b1, 1'b1, 32'h30, 32'h0000BEEF, 4'h3);
    tick();
    chk("rstmerge_access_rd", {31'b0, MemRead}, 32'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstmerge_no_write", {31'b0, MemWrite}, 32'h0);
    chk("rstmerge_no_gnt", {31'b0, d_gnt}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmerge_word_kept", mem[8'h0C], 32'h11111111);
    chk("rstmerge_idle", {31'b0, busy}, 32'h0);
    gcyc = 0;
    for (cyc = 2; cyc <= 10; cyc++) begin
      tick();
      if (d_gnt) begin
        gcyc = cyc;
        break;
      end
    end
    d_req = 1'b0;
    chk("rstmerge_retry_latency", gcyc, 3);
    tick();
    chk("rstmerge_retry_word", mem[8'h0C], 32'h1111BEEF);

    // Both held permanently after reset: strict c,d,c,d alternation, 2 cycles apart.
    do_reset(1);
    mem[1] = 32'h11110001;
    mem[2] = 32'h22220002;
    drive(1'b0, 1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
    gcyc = 0;
    for (cyc = 2; cyc <= 40 && order.size() < 8; cyc++) begin
      tick();
      if (c_gnt) order.push_back(1'b0);
      if (d_gnt) order.push_back(1'b1);
      if (order.size() == 1 && gcyc == 0) gcyc = cyc;
    end
    c_req = 1'b0;
    d_req = 1'b0;
    chk("alt_first_gnt_cycle", gcyc, 2);
    chk("alt_grant_count", order.size(), 8);
    for (int k = 0; k < order.size(); k++)
      chk($sformatf("alt_order%0d", k), {31'b0, order[k]}, k % 2);
    tick();

    // Randomized two-port episodes.
    do_reset(1);
    last_p = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      gm[i]  = mem[i];
    end
    for (int e = 0; e < 80; e++) episode();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
